spi_rx: RTL and testbench

- SPI target (receiver) for the SoC: the receiving end of the transmit-only SPI master link (spi_cs/spi_clk/spi_mosi).
- Deserialises MOSI bytes into an RX FIFO.
- Exposes data/status/control to the CPU as a memory-mapped slave on the shared select/wstrb/addr/ready bus.
- Raises an interrupt line for the CPU irq vector.

---
 rtl/spi_rx_pkg.sv | 26 ++
 rtl/spi_rx_sync_fifo.sv | 49 ++++
 rtl/spi_rx.sv | 186 ++++++++++++++++++
 tb/tb_spi_rx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared constants and types for the SPI receiver: register offsets,
// CTRL/STATUS bit positions and the receive FSM state type.
package spi_rx_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_CLR_OVR = 2;
  localparam int CTRL_FLUSH   = 3;
  localparam int CTRL_LSB     = 4;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVR       = 2;
  localparam int ST_BUSY      = 3;
  localparam int ST_LEVEL_LSB = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/spi_rx_sync_fifo.sv
// Single-clock FIFO with flush and fill level; pops while empty are ignored
// and pushes while full succeed only when a pop frees a slot in that cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 target: synchronises the link, deserialises bytes into a FIFO
// and exposes DATA/STATUS/CTRL on the bus. SPI_RX_LSB_FIRST_EN adds CTRL[4].
//
//   state | meaning
//   IDLE  | link deselected or receiver disabled; bit counter held at 0
//   SHIFT | cs low and enabled; sampling mosi on each spi_clk rising edge
module spi_rx
  import spi_rx_pkg::*;
#(
  parameter  int FIFO_DEPTH  = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  input  logic        spi_cs,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic        irq
);

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic cs_s, sclk_s, mosi_s, sclk_prev, sclk_rise;

  rx_state_e state, state_next;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, shreg_next;
  logic shift_en, push, busy;

  logic served, rd_en, wr_en, ctrl_wr, pop, flush, clr_ovr;
  logic ctrl_en, ctrl_irq_en, ctrl_lsb, ovr;
  logic ctrl_en_next, ctrl_irq_en_next, ovr_next;
  logic fifo_full, fifo_empty, pop_ok, push_ok, push_drop;
  logic [7:0]    fifo_dout;
  logic [LW-1:0] fifo_level, level_next;
  logic [31:0]   rdata;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!cs_s && ctrl_en) state_next = SHIFT;
      SHIFT:   if (cs_s || !ctrl_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == SHIFT);
    shift_en = busy && !cs_s && ctrl_en && sclk_rise;
    push     = shift_en && (bit_cnt == 3'd7);
  end

`ifdef SPI_RX_LSB_FIRST_EN
  assign shreg_next = ctrl_lsb ? {mosi_s, shreg[7:1]} : {shreg[6:0], mosi_s};
`else
  assign shreg_next = {shreg[6:0], mosi_s};
`endif

  // Leaving SHIFT zeroes the counter, which is what discards a partial byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (state != SHIFT) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 3'd1;
      shreg   <= shreg_next;
    end
  end

  assign rd_en   = ready && (wstrb == 4'h0);
  assign wr_en   = ready && (wstrb != 4'h0);
  assign pop     = rd_en && (addr[3:2] == ADDR_DATA[3:2]);
  assign ctrl_wr = wr_en && (addr[3:2] == ADDR_CTRL[3:2]) && wstrb[0];
  assign clr_ovr = ctrl_wr && data_i[CTRL_CLR_OVR];
  assign flush   = ctrl_wr && data_i[CTRL_FLUSH];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (shreg_next),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Mirror of the FIFO's accept rules so irq can follow the post-edge state.
  assign pop_ok     = pop & ~fifo_empty;
  assign push_ok    = push & (~fifo_full | pop_ok);
  assign push_drop  = push & fifo_full & ~pop_ok & ~flush;
  assign level_next = flush ? '0 : fifo_level + LW'(push_ok) - LW'(pop_ok);

  assign ctrl_en_next     = ctrl_wr ? data_i[CTRL_EN]     : ctrl_en;
  assign ctrl_irq_en_next = ctrl_wr ? data_i[CTRL_IRQ_EN] : ctrl_irq_en;
  assign ovr_next         = push_drop ? 1'b1 : (clr_ovr ? 1'b0 : ovr);

  always_ff @(posedge clk) begin
    if (reset) begin
      ready       <= 1'b0;
      served      <= 1'b0;
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ovr         <= 1'b0;
      irq         <= 1'b0;
    end else begin
      // served keeps a held select from producing a second ready pulse
      ready       <= select & ~ready & ~served;
      served      <= select & (served | ready);
      ctrl_en     <= ctrl_en_next;
      ctrl_irq_en <= ctrl_irq_en_next;
      ovr         <= ovr_next;
      irq         <= ctrl_irq_en_next & ((level_next != '0) | ovr_next);
    end
  end

`ifdef SPI_RX_LSB_FIRST_EN
  always_ff @(posedge clk) begin
    if (reset)        ctrl_lsb <= 1'b0;
    else if (ctrl_wr) ctrl_lsb <= data_i[CTRL_LSB];
  end
  logic unused_ok;
  assign unused_ok = ^{addr[1:0], data_i[31:5], wstrb[3:1]};
`else
  assign ctrl_lsb = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{addr[1:0], data_i[31:4], wstrb[3:1], ctrl_lsb};
`endif

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      ADDR_DATA[3:2]: rdata[7:0] = fifo_dout;
      ADDR_STATUS[3:2]: begin
        rdata[ST_NOT_EMPTY]             = ~fifo_empty;
        rdata[ST_FULL]                  = fifo_full;
        rdata[ST_OVR]                   = ovr;
        rdata[ST_BUSY]                  = busy;
        rdata[ST_LEVEL_LSB +: 9]        = 9'(fifo_level);
      end
      ADDR_CTRL[3:2]: begin
        rdata[CTRL_EN]     = ctrl_en;
        rdata[CTRL_IRQ_EN] = ctrl_irq_en;
        rdata[CTRL_LSB]    = ctrl_lsb;
      end
      default: rdata = '0;
    endcase
  end

  assign data_o = ready ? rdata : 32'h0;

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: directed SPI frames and bus accesses,
// a queue-based register model checked every cycle, plus literal checks.
module tb_spi_rx;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        select = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] data_i = 32'h0;
  logic        ready;
  logic [31:0] data_o;
  logic        spi_cs = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        irq;

  spi_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .select(select), .wstrb(wstrb), .addr(addr),
    .data_i(data_i), .ready(ready), .data_o(data_o), .spi_cs(spi_cs),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // register-level model
  logic [7:0] q[$];
  logic m_ovr = 0, m_en = 0, m_irq_en = 0, m_lsb = 0, m_busy = 0;
  logic quiet = 0;
  int   negcnt = 0;
  int   rise_neg = -10;
  logic sel_prev = 0;
  logic exp_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a[3:2])
      2'd0: if (q.size() != 0) r[7:0] = q[0];
      2'd1: begin
        r[0]    = (q.size() != 0);
        r[1]    = (q.size() == DEPTH);
        r[2]    = m_ovr;
        r[3]    = m_busy;
        r[16:8] = 9'(q.size());
      end
      2'd2: begin
        r[0] = m_en;
        r[1] = m_irq_en;
        r[4] = m_lsb;
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Every-cycle compare against the model; also applies bus side effects.
  always @(negedge clk) begin
    if (reset) begin
      sel_prev = 1'b0;
      rise_neg = -10;
    end else begin
      negcnt++;
      exp_rdy = (negcnt == rise_neg + 1);
      if (select && !sel_prev) rise_neg = negcnt;
      sel_prev = select;
      check("ready", {31'h0, ready}, {31'h0, exp_rdy});
      if (quiet) check("irq", {31'h0, irq}, {31'h0, m_irq_en && (q.size() != 0 || m_ovr)});
      if (exp_rdy) begin
        if (wstrb == 4'h0) begin
          check("data_o", data_o, model_read(addr));
          if (addr[3:2] == 2'd0 && q.size() != 0) void'(q.pop_front());
        end else if (addr[3:2] == 2'd2 && wstrb[0]) begin
          m_en     = data_i[0];
          m_irq_en = data_i[1];
          if (data_i[2]) m_ovr = 1'b0;
          if (data_i[3]) q.delete();
`ifdef SPI_RX_LSB_FIRST_EN
          m_lsb = data_i[4];
`endif
        end
      end else begin
        check("data_o_idle", data_o, 32'h0);
      end
    end
  end

  task automatic bus_xfer(input logic [3:0] a, input logic [3:0] s, input logic [31:0] wd,
                          output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    select = 1'b1; addr = a; wstrb = s; data_i = wd;
    n = 0;
    @(negedge clk);
    while (!ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL bus_timeout actual=no_ready expected=ready addr=0x%0h", a);
    end
    rd = data_o;
    @(posedge clk); #1;
    select = 1'b0; wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] rd);
    bus_xfer(a, 4'h0, 32'h0, rd);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_xfer(a, 4'hF, wd, dummy);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    @(posedge clk); #1;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      repeat (4) @(posedge clk);
      #1 spi_clk = 1'b1;
      repeat (4) @(posedge clk);
      #1 spi_clk = 1'b0;
    end
  endtask

  task automatic model_push(input logic [7:0] wire_b);
    logic [7:0] v;
    v = m_lsb ? rev8(wire_b) : wire_b;
    if (m_en) begin
      if (q.size() < DEPTH) q.push_back(v);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic cs_low();
    @(posedge clk); #1;
    quiet = 1'b0;
    spi_cs = 1'b0;
    m_busy = m_en;
    repeat (4) @(posedge clk);
  endtask

  task automatic cs_high();
    @(posedge clk); #1;
    spi_cs = 1'b1;
    m_busy = 1'b0;
    repeat (6) @(posedge clk);
    #1 quiet = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cs_low();
    spi_bits(b, 8);
    model_push(b);
    cs_high();
  endtask

  logic [31:0] rd;
  int nrdy, first_rdy;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    quiet = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_data_o", data_o, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    bus_read(4'h4, rd); check("rst_status", rd, 32'h0);
    bus_read(4'h8, rd); check("rst_ctrl", rd, 32'h0);

    // single byte
    bus_write(4'h8, 32'h1);
    send_byte(8'hA5);
    bus_read(4'h4, rd); check("byte_status", rd, 32'h0000_0101);
    bus_read(4'h0, rd); check("byte_data", rd, 32'h0000_00A5);
    bus_read(4'h4, rd); check("byte_status_after", rd, 32'h0);
    bus_read(4'h0, rd); check("empty_data", rd, 32'h0);

    // burst into overrun
    cs_low();
    for (int i = 1; i <= 9; i++) begin
      spi_bits(8'(i), 8);
      model_push(8'(i));
    end
    cs_high();
    bus_read(4'h4, rd); check("burst_status", rd, 32'h0000_0807);
    for (int i = 1; i <= 8; i++) begin
      bus_read(4'h0, rd); check("burst_data", rd, 32'(i));
    end
    bus_read(4'h4, rd); check("burst_ovr_kept", rd, 32'h0000_0004);
    bus_write(4'h8, 32'h5);
    bus_read(4'h4, rd); check("ovr_cleared", rd, 32'h0);

    // partial frame
    cs_low();
    spi_bits(8'hB0, 5);
    bus_read(4'h4, rd); check("partial_busy", rd, 32'h0000_0008);
    cs_high();
    bus_read(4'h4, rd); check("partial_idle", rd, 32'h0);
    send_byte(8'h3C);
    bus_read(4'h0, rd); check("after_partial", rd, 32'h0000_003C);

    // interrupt
    bus_write(4'h8, 32'h3);
    cs_low();
    spi_bits(8'h11, 8);
    model_push(8'h11);
    check("irq_set", {31'h0, irq}, 32'h1);
    cs_high();
    bus_read(4'h0, rd); check("irq_data", rd, 32'h0000_0011);
    check("irq_clear", {31'h0, irq}, 32'h0);
    bus_write(4'h8, 32'h1);

    // flush
    send_byte(8'h55);
    bus_write(4'h8, 32'h9);
    bus_read(4'h4, rd); check("flush_status", rd, 32'h0);

    // handshake with select held
    @(posedge clk); #1;
    select = 1'b1; addr = 4'h4; wstrb = 4'h0;
    nrdy = 0; first_rdy = -1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (ready) begin
        nrdy++;
        if (first_rdy < 0) first_rdy = i;
      end
    end
    @(posedge clk); #1 select = 1'b0;
    check("hold_ready_count", 32'(nrdy), 32'd1);
    check("hold_ready_cycle", 32'(first_rdy), 32'd2);
    bus_read(4'hC, rd); check("reg_c", rd, 32'h0);
    bus_read(4'h8, rd); check("ctrl_en", rd, 32'h1);

    // reset mid-frame
    cs_low();
    spi_bits(8'hAA, 4);
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    m_ovr = 0; m_en = 0; m_irq_en = 0; m_lsb = 0; m_busy = 0;
    spi_cs = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus_read(4'h8, rd); check("ctrl_after_reset", rd, 32'h0);
    bus_write(4'h8, 32'h1);
    send_byte(8'h7E);
    bus_read(4'h4, rd); check("reset_level", rd, 32'h0000_0101);
    bus_read(4'h0, rd); check("reset_data", rd, 32'h0000_007E);

`ifdef SPI_RX_LSB_FIRST_EN
    bus_write(4'h8, 32'h11);
    bus_read(4'h8, rd); check("ctrl_lsb", rd, 32'h11);
    send_byte(8'h80);
    bus_read(4'h0, rd); check("lsb_data_01", rd, 32'h0000_0001);
    send_byte(8'h7E);
    bus_read(4'h0, rd); check("lsb_data_7e", rd, 32'h0000_007E);
`else
    bus_write(4'h8, 32'h11);
    bus_read(4'h8, rd); check("ctrl_lsb_ignored", rd, 32'h1);
    send_byte(8'h80);
    bus_read(4'h0, rd); check("msb_data_80", rd, 32'h0000_0080);
`endif

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
